// File: rtl/dram_pkg.sv
// Shared definitions for initiators on the 4-port data RAM.
package dram_pkg;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MEM_WORDS = 3075;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    FIN
  } dma_state_t;

  // True when [base, base+len-1] lies inside the implemented RAM; evaluated one bit wider than ADDR_W.
  function automatic logic in_range(input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] len);
    logic [ADDR_W:0] last;
    if (len == '0) return 1'b1;
    last = {1'b0, base} + {1'b0, len} - 1'b1;
    return last < (ADDR_W+1)'(MEM_WORDS);
  endfunction

endpackage

// File: rtl/dram_dma_copy_if.sv
// Request/status and RAM-port signals of the block-copy engine.
interface dram_dma_copy_if;
  import dram_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] len;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output start, src, dst, len, mem_rdata,
    input  busy, done, err, count, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  start, src, dst, len, mem_rdata,
    output busy, done, err, count, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/dram_dma_copy.sv
// Single-channel word copy engine owning one RAM port: alternating READ/WRITE
// cycles, strictly ascending addresses, bounds-checked at request time.
module dram_dma_copy
  import dram_pkg::*;
(
  input logic            clk,
  input logic            rst,
  dram_dma_copy_if.slave bus
);

  dma_state_t        r_state;
  dma_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_count;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic              w_reject;
  logic [ADDR_W-1:0] w_count_inc;

  assign w_reject    = !(in_range(bus.src, bus.len) && in_range(bus.dst, bus.len));
  assign w_count_inc = r_count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_src   <= bus.src;
            r_dst   <= bus.dst;
            r_len   <= bus.len;
            r_count <= '0;
            r_err   <= w_reject;
          end
        end
        READ:    r_data  <= bus.mem_rdata;
        WRITE:   r_count <= w_count_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_reject || bus.len == '0) w_state_nxt = FIN;
          else                           w_state_nxt = READ;
        end
      end
      READ:    w_state_nxt = WRITE;
      WRITE:   w_state_nxt = (w_count_inc == r_len) ? FIN : READ;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    unique case (r_state)
      READ:  bus.mem_addr = r_src + r_count;
      WRITE: begin
        bus.mem_addr  = r_dst + r_count;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = r_data;
      end
      default: ;
    endcase
  end

  assign bus.busy  = (r_state != IDLE);
  assign bus.done  = (r_state == FIN);
  assign bus.err   = (r_state == FIN) && r_err;
  assign bus.count = r_count;

endmodule

// File: tb/tb_dram_dma_copy.sv
// Bench for dram_dma_copy: RAM model, array reference model, table and random copies.
module tb_dram_dma_copy;
  import dram_pkg::*;

  typedef struct {
    int   src;
    int   dst;
    int   len;
    logic e_err;
    int   e_lat;
    int   e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_dma_copy_if bus();

  dram_dma_copy dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] ram   [0:MEM_WORDS-1];
  logic [31:0] model [0:MEM_WORDS-1];
  int          wlog  [0:16383];
  int          nwr = 0;
  logic        pl_clr = 1'b1;
  logic        pl_we  = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  int total = 0;
  int bad   = 0;

  assign bus.mem_rdata = (int'(bus.mem_addr) < MEM_WORDS) ? ram[bus.mem_addr] : '0;

  always @(posedge clk) begin
    if (pl_clr) begin
      for (int i = 0; i < MEM_WORDS; i++) ram[i] <= '0;
    end else if (pl_we) begin
      ram[pl_addr] <= pl_data;
    end else if (bus.mem_we && int'(bus.mem_addr) < MEM_WORDS) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
      wlog[nwr % 16384] <= int'(bus.mem_addr);
      nwr <= nwr + 1;
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (ram[i] !== model[i]) n++;
    return n;
  endfunction

  task automatic poke(input int a, input logic [31:0] v);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a[11:0]; pl_data = v;
    @(posedge clk);
    #1 pl_we = 1'b0;
    model[a] = v;
  endtask

  task automatic preload(input int s, input int l);
    for (int i = 0; i < l; i++) poke(s + i, $urandom);
  endtask

  // Issues one request and checks latency, err, count, write addresses and RAM image.
  task automatic run_copy(input int s, input int d, input int l, input int inj,
                          input logic e_err, input int e_lat, input int e_cnt);
    int   base;
    int   lat;
    int   nbusy;
    int   wbad;
    int   cnt;
    int   nw;
    logic got_err;
    base = nwr; lat = -1; nbusy = 0; cnt = 0; got_err = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.src = s[11:0]; bus.dst = d[11:0]; bus.len = l[11:0];
    for (int cyc = 1; cyc <= e_lat + 8 && lat < 0; cyc++) begin
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      if (cyc == 1) check("count_cleared", bus.count, 0);
      if (!bus.busy) nbusy++;
      if (bus.done) begin
        lat = cyc; got_err = bus.err; cnt = int'(bus.count);
      end else if (bus.err) nbusy++;
      if (cyc == inj) begin
        bus.start = 1'b1; bus.src = 12'h700; bus.dst = 12'h7F0; bus.len = 12'd9;
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL done_timeout: src=%0d dst=%0d len=%0d no done seen", s, d, l);
    end else begin
      check("done_latency", lat, e_lat);
      check("err", got_err, e_err);
      check("count", cnt, e_cnt);
    end
    check("busy_or_err_glitch", nbusy, 0);
    nw = nwr - base;
    check("write_count", nw, (e_err || l == 0) ? 0 : l);
    wbad = 0;
    for (int k = 0; k < nw && k < 4096; k++)
      if (wlog[(base + k) % 16384] != d + k) wbad++;
    check("write_addr_seq", wbad, 0);
    if (!e_err) for (int i = 0; i < l; i++) model[d + i] = model[s + i];
    check("mem_image", mem_diff(), 0);
  endtask

  vec_t tbl [10];

  initial begin
    int s, d, l, lat, cnt, r;
    logic e;
    int saw_done;

    tbl[0] = '{16'h010, 16'h100, 4,    1'b0, 9,  4};
    tbl[1] = '{16'h020, 16'h040, 0,    1'b0, 1,  0};
    tbl[2] = '{3072,    0,       4,    1'b1, 1,  0};
    tbl[3] = '{0,       3071,    4,    1'b0, 9,  4};
    tbl[4] = '{0,       3072,    4,    1'b1, 1,  0};
    tbl[5] = '{3074,    5,       1,    1'b0, 3,  1};
    tbl[6] = '{0,       0,       4095, 1'b1, 1,  0};
    tbl[7] = '{4095,    0,       0,    1'b0, 1,  0};
    tbl[8] = '{16'h050, 16'h048, 6,    1'b0, 13, 6};
    tbl[9] = '{3070,    3060,    5,    1'b0, 11, 5};

    bus.start = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
    for (int i = 0; i < MEM_WORDS; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  bus.busy,      0);
    check("rst_done",  bus.done,      0);
    check("rst_err",   bus.err,       0);
    check("rst_count", bus.count,     0);
    check("rst_we",    bus.mem_we,    0);
    check("rst_addr",  bus.mem_addr,  0);
    check("rst_wdata", bus.mem_wdata, 0);
    rst = 1'b0; pl_clr = 1'b0;

    for (int t = 0; t < 10; t++) begin
      if (!tbl[t].e_err) preload(tbl[t].src, tbl[t].len);
      run_copy(tbl[t].src, tbl[t].dst, tbl[t].len, 0,
               tbl[t].e_err, tbl[t].e_lat, tbl[t].e_cnt);
      @(negedge clk);
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);
      check("idle_we",   bus.mem_we, 0);
      check("idle_addr", bus.mem_addr, 0);
    end

    // Forward overlap with a stray start mid-copy
    poke(0, 32'd7); poke(1, 32'd8); poke(2, 32'd9); poke(3, 32'hDEAD);
    run_copy(0, 1, 3, 3, 1'b0, 7, 3);
    check("overlap_w1", ram[1], 7);
    check("overlap_w2", ram[2], 7);
    check("overlap_w3", ram[3], 7);

    // Back-to-back: second request in the cycle right after FIN
    preload(16'h400, 5);
    run_copy(16'h400, 16'h480, 5, 0, 1'b0, 11, 5);
    run_copy(16'h480, 16'h500, 3, 0, 1'b0, 7, 3);

    // Reset during the WRITE of the third word
    preload(16'h200, 8);
    for (int i = 0; i < 8; i++) poke(16'h300 + i, 32'h5A5A0000 + i);
    r = nwr;
    @(negedge clk);
    bus.start = 1'b1; bus.src = 12'h200; bus.dst = 12'h300; bus.len = 12'd8;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 6; c++) @(negedge clk);
    check("rstmid_we",   bus.mem_we, 1);
    check("rstmid_addr", bus.mem_addr, 16'h302);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_done", bus.done, 0);
    saw_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done++;
    end
    check("rstmid_quiet", saw_done, 0);
    check("rstmid_writes", nwr - r, 3);
    for (int i = 0; i < 3; i++) model[16'h300 + i] = model[16'h200 + i];
    check("rstmid_mem", mem_diff(), 0);

    // Randomized requests against the array model
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 3);
      l = $urandom_range(0, 24);
      case (r)
        0: begin s = $urandom_range(0, 4095); d = $urandom_range(0, 4095); end
        1: begin s = $urandom_range(0, 3000); d = (s + $urandom_range(0, 3)) % 4096; end
        2: begin s = $urandom_range(3040, 3074); d = $urandom_range(0, 3074); end
        default: begin s = $urandom_range(0, 3074); d = $urandom_range(3040, 3074); end
      endcase
      e   = (l != 0) && (s + l > MEM_WORDS || d + l > MEM_WORDS);
      lat = (e || l == 0) ? 1 : 2 * l + 1;
      cnt = e ? 0 : l;
      if (!e) preload(s, l);
      run_copy(s, d, l, (t % 3 == 0) ? 2 : 0, e, lat, cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
